// File: rtl/prince_inv_sbox_masked.sv
// prince_inv_sbox_masked: 3-share masked PRINCE inverse S-box, 4-rank pipeline with valid/ready and fresh-randomness handshake.
// Shares of every ANF monomial of S^-1 are built by non-complete threshold ANDs, then recombined share-wise.
module prince_inv_sbox_masked #(
  parameter int RAND_W    = 16,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in1,
  input  logic [3:0]        in2,
  input  logic [3:0]        in3,
  input  logic [RAND_W-1:0] r,
  input  logic              rnd_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out1,
  output logic [3:0]        out2,
  output logic [3:0]        out3
);
  localparam logic [63:0] SINV = 64'h1CE5_046A_98DF_237B;

  function automatic logic [63:0] anf_of(input logic [63:0] t);
    logic [63:0] a;
    a = '0;
    for (int b = 0; b < 4; b++)
      for (int m = 0; m < 16; m++)
        for (int u = 0; u < 16; u++)
          if ((u & ~m) == 0) a[b*16+m] = a[b*16+m] ^ t[u*4+b];
    return a;
  endfunction

  // share i of the product never sees share i of either operand
  function automatic logic [2:0] ti_and(input logic [2:0] a, input logic [2:0] b);
    return {a[0] & b[0] ^ a[0] & b[1] ^ a[1] & b[0],
            a[2] & b[2] ^ a[0] & b[2] ^ a[2] & b[0],
            a[1] & b[1] ^ a[1] & b[2] ^ a[2] & b[1]};
  endfunction

  localparam logic [63:0] ANF = anf_of(SINV);
  localparam int PM [6] = '{3, 5, 9, 6, 10, 12};
  localparam int PA [6] = '{0, 0, 0, 1, 1, 2};
  localparam int PB [6] = '{1, 2, 3, 2, 3, 3};
  localparam int CM [4] = '{7, 11, 13, 14};
  localparam int CP [4] = '{0, 0, 1, 3};
  localparam int CX [4] = '{2, 3, 3, 3};

  logic       w_adv;
  logic [2:0] r_x0 [4];
  logic [2:0] r_x1 [4];
  logic [2:0] r_x2 [4];
  logic [2:0] r_q1 [6];
  logic [2:0] r_q2 [6];
  logic [2:0] r_c2 [4];
  logic [2:0] w_m  [16];
  logic [3:0] w_o  [3];
  logic [3:0] r_o  [3];
  logic       r_v0, r_v1, r_v2, r_v3;

  assign w_adv     = rst_i & rnd_valid & (out_ready | ~r_v3);
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign out1      = (ZERO_IDLE && !r_v3) ? 4'h0 : r_o[0];
  assign out2      = (ZERO_IDLE && !r_v3) ? 4'h0 : r_o[1];
  assign out3      = (ZERO_IDLE && !r_v3) ? 4'h0 : r_o[2];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      {r_v0, r_v1, r_v2, r_v3} <= '0;
      for (int b = 0; b < 4; b++) begin
        r_x0[b] <= '0;
        r_x1[b] <= '0;
        r_x2[b] <= '0;
        r_c2[b] <= '0;
      end
      for (int p = 0; p < 6; p++) begin
        r_q1[p] <= '0;
        r_q2[p] <= '0;
      end
      for (int s = 0; s < 3; s++) r_o[s] <= '0;
    end else if (w_adv) begin
      {r_v0, r_v1, r_v2, r_v3} <= {in_valid, r_v0, r_v1, r_v2};
      for (int b = 0; b < 4; b++) begin
        r_x0[b] <= {in3[b], in2[b], in1[b]};
        r_x1[b] <= r_x0[b] ^ {r[7], r[6] ^ r[7], r[6]};
        r_x2[b] <= r_x1[b];
      end
      for (int p = 0; p < 6; p++)
        r_q1[p] <= ti_and(r_x0[PA[p]], r_x0[PB[p]]) ^ {1'b0, r[p], r[p]};
      for (int p = 0; p < 4; p++) r_q2[p] <= r_q1[p] ^ {r[12+p], r[12+p], 1'b0};
      r_q2[4] <= r_q1[4];
      r_q2[5] <= r_q1[5];
      for (int k = 0; k < 4; k++)
        r_c2[k] <= ti_and(r_q1[CP[k]], r_x1[CX[k]]) ^ {1'b0, r[8+k], r[8+k]};
      for (int s = 0; s < 3; s++) r_o[s] <= w_o[s];
    end
  end

  // the constant monomial lives only in share 0
  always_comb begin
    for (int m = 0; m < 16; m++) w_m[m] = '0;
    w_m[0] = 3'b001;
    for (int b = 0; b < 4; b++) w_m[1 << b] = r_x2[b];
    for (int p = 0; p < 6; p++) w_m[PM[p]] = r_q2[p];
    for (int k = 0; k < 4; k++) w_m[CM[k]] = r_c2[k];
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++) begin
        w_o[s][b] = 1'b0;
        for (int m = 0; m < 16; m++) w_o[s][b] = w_o[s][b] ^ (ANF[b*16+m] & w_m[m][s]);
      end
  end
endmodule

// File: tb/tb_prince_inv_sbox_masked.sv
// tb_prince_inv_sbox_masked: randomized scenario bench, S^-1 table lookup and an in-order queue as reference.
module tb_prince_inv_sbox_masked;
  logic        clk = 1'b0;
  logic        rst_i, in_valid, in_ready, rnd_valid, out_valid, out_ready;
  logic [3:0]  in1, in2, in3, out1, out2, out3;
  logic [15:0] r;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q [$];
  logic [3:0]  sinv_t [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
  logic [3:0]  sbox_t [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  prince_inv_sbox_masked dut (
    .clk(clk), .rst_i(rst_i), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3), .r(r), .rnd_valid(rnd_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2), .out3(out3)
  );

  always #5 clk = ~clk;

  task automatic share(input logic [3:0] v);
    in1 = 4'($urandom);
    in2 = 4'($urandom);
    in3 = v ^ in1 ^ in2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] xo();
    return out1 ^ out2 ^ out3;
  endfunction

  task automatic test_reset();
    rst_i = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    share(4'h5);
    r = 16'($urandom);
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({out1, out2, out3} !== 12'h0) begin n_bad++; $display("FAIL reset_outs: got %h expected 000", {out1, out2, out3}); end
    tick();
    rst_i = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat = -1;
    in_valid = 1'b1; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0; r = 16'h0; out_ready = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_in_ready: got %b expected 1", in_ready); end
      end
      if (c == 3) begin
        n_cmp++; if ({out_valid, out1, out2, out3} !== 13'h0) begin n_bad++; $display("FAIL zero_idle: got %h expected 0000", {out_valid, out1, out2, out3}); end
      end
      if (out_valid === 1'b1 && lat < 0) begin
        lat = c;
        n_cmp++; if (xo() !== 4'hB) begin n_bad++; $display("FAIL zero_value: got %h expected b", xo()); end
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL zero_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_back_to_back(input bit rt);
    int i = 0, got = 0, first = -1, last = -1;
    int off = $urandom_range(15);
    logic [3:0] x [16];
    for (int k = 0; k < 16; k++) x[k] = 4'(k + off);
    exp_q.delete();
    out_ready = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      in_valid = (i < 16);
      if (i < 16) share(rt ? sbox_t[x[i]] : x[i]);
      r = 16'($urandom);
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || xo() !== exp_q[0]) begin
          n_bad++; $display("FAIL b2b_value(rt=%0d) beat %0d: got %h expected %h", rt, got, xo(), exp_q.size() ? exp_q[0] : 4'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(rt ? x[i] : sinv_t[x[i]]);
        i++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 16 || last - first != 15) begin
      n_bad++; $display("FAIL b2b_count(rt=%0d): got %0d beats over %0d cycles expected 16 over 16", rt, got, last - first + 1);
    end
  endtask

  task automatic test_out_stall();
    int i = 0, got = 0;
    logic [3:0] xv;
    logic [11:0] held = '0;
    exp_q.delete();
    rnd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 4 && c < 7);
      in_valid = (i < 4);
      xv = 4'($urandom);
      share(xv);
      r = 16'($urandom);
      @(negedge clk);
      if (c == 4) held = {out1, out2, out3};
      if (c >= 4 && c < 7) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out1, out2, out3} !== held) begin
          n_bad++; $display("FAIL out_stall_hold c%0d: got rdy=%b v=%b %h expected rdy=0 v=1 %h", c, in_ready, out_valid, {out1, out2, out3}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0 || xo() !== exp_q[0]) begin
          n_bad++; $display("FAIL out_stall_value beat %0d: got %h expected %h", got, xo(), exp_q.size() ? exp_q[0] : 4'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(sinv_t[xv]);
        i++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL out_stall_count: got %0d expected 4", got); end
  endtask

  task automatic test_rnd_stall();
    int i = 0, got = 0;
    logic [3:0] xv;
    logic [12:0] snap = '0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      rnd_valid = !(c == 5 || c == 6);
      in_valid = (i < 8);
      xv = 4'($urandom);
      share(xv);
      r = 16'($urandom);
      @(negedge clk);
      if (c == 5) snap = {out_valid, out1, out2, out3};
      if (c == 5 || c == 6) begin
        n_cmp++;
        if (in_ready !== 1'b0 || {out_valid, out1, out2, out3} !== snap || out_valid !== 1'b1) begin
          n_bad++; $display("FAIL rnd_stall_hold c%0d: got rdy=%b %h expected rdy=0 %h", c, in_ready, {out_valid, out1, out2, out3}, snap);
        end
      end
      if (out_valid && out_ready && rnd_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || xo() !== exp_q[0]) begin
          n_bad++; $display("FAIL rnd_stall_value beat %0d: got %h expected %h", got, xo(), exp_q.size() ? exp_q[0] : 4'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(sinv_t[xv]);
        i++;
      end
      tick();
    end
    in_valid = 1'b0; rnd_valid = 1'b1;
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL rnd_stall_count: got %0d expected 8", got); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      rst_i = (c != 3);
      in_valid = (c < 3);
      share(4'($urandom));
      r = 16'($urandom);
      @(negedge clk);
      if (c == 3) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || {out1, out2, out3} !== 12'h0) begin
          n_bad++; $display("FAIL mid_reset: got rdy=%b v=%b %h expected rdy=0 v=0 000", in_ready, out_valid, {out1, out2, out3});
        end
      end
      if (c > 3) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale c%0d: got out_valid=%b expected 0", c, out_valid); end
      end
      tick();
    end
    rst_i = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; r = '0;
    test_reset();
    test_zero();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_out_stall();
    test_rnd_stall();
    test_reset_mid();
    test_back_to_back(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
